press_sequence_decoder: RTL and testbench

Consumes the one-cycle `short`/`long` press events produced by the button classifier and assembles them into a symbol word, Morse-style. A word ends after `gap` idle cycles; the block then presents the word with a one-cycle `code_valid` strobe. Words longer than `maxlen` symbols are discarded and flagged with a one-cycle `error` strobe. It sits between the button classifier and the calculator key-command logic.

---
 rtl/press_sequence_decoder_if.sv | 26 ++
 rtl/press_sequence_decoder.sv | 130 +++++++++++++
 tb/tb_press_sequence_decoder.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/press_sequence_decoder_if.sv
`default_nettype none
// ============================================================================
// press_sequence_decoder_if : press events in, assembled symbol words out
// Rev 1.0
// ============================================================================
interface press_sequence_decoder_if #(
  parameter int unsigned maxlen = 4
);
  logic              short;
  logic              long;
  logic [maxlen-1:0] code;
  logic [2:0]        len;
  logic              code_valid;
  logic              error;

  modport master (
    output short, long,
    input  code, len, code_valid, error
  );

  modport slave (
    input  short, long,
    output code, len, code_valid, error
  );
endinterface
`default_nettype wire

// File: rtl/press_sequence_decoder.sv
`default_nettype none
// ============================================================================
// press_sequence_decoder : assembles short/long press events into Morse-style
// words, closed by an idle gap; over-length words are dropped with an error.
// Rev 1.0
// ============================================================================
module press_sequence_decoder #(
  parameter int unsigned gap    = 25000000,
  parameter int unsigned maxlen = 4
) (
  input  wire logic              Clock,
  input  wire logic              Reset,
  press_sequence_decoder_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_COL  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_OVF  = 2'd3;

  localparam logic [31:0] c_gap    = 32'(gap);
  localparam logic [2:0]  c_maxlen = 3'(maxlen);

  logic [1:0]        r_state, w_state_nxt;
  logic [31:0]       r_count, w_count_nxt;
  logic [maxlen-1:0] r_code,  w_code_nxt;
  logic [2:0]        r_len,   w_len_nxt;

  logic              w_event;
  logic              w_sym;
  logic [maxlen-1:0] w_first;
  logic [maxlen-1:0] w_shifted;
  logic              w_code_valid;
  logic              w_error;

  // A simultaneous short+long is one long symbol, so the symbol is just 'long'.
  assign w_event = bus.short | bus.long;
  assign w_sym   = bus.long;

  always_comb begin
    w_first    = '0;
    w_first[0] = w_sym;
  end

  generate
    if (maxlen == 1) begin : g_shift_one
      assign w_shifted = w_sym;
    end else begin : g_shift_wide
      assign w_shifted = {r_code[maxlen-2:0], w_sym};
    end
  endgenerate

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_count <= c_gap;
      r_code  <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_code  <= w_code_nxt;
      r_len   <= w_len_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_code_nxt  = r_code;
    w_len_nxt   = r_len;
    case (r_state)
      S_IDLE, S_EMIT: begin
        if (w_event) begin
          w_code_nxt  = w_first;
          w_len_nxt   = 3'd1;
          w_count_nxt = c_gap;
          w_state_nxt = S_COL;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_COL: begin
        // Events beat the timeout, even in the cycle where count has hit zero.
        if (w_event) begin
          w_count_nxt = c_gap;
          if (r_len < c_maxlen) begin
            w_code_nxt = w_shifted;
            w_len_nxt  = r_len + 3'd1;
          end else begin
            w_state_nxt = S_OVF;
          end
        end else if (r_count == 32'd0) begin
          w_state_nxt = S_EMIT;
        end else begin
          w_count_nxt = r_count - 32'd1;
        end
      end
      S_OVF: begin
        if (w_event) begin
          w_count_nxt = c_gap;
        end else if (r_count == 32'd0) begin
          w_code_nxt  = '0;
          w_len_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_count_nxt = r_count - 32'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_code_nxt  = '0;
        w_len_nxt   = '0;
        w_count_nxt = c_gap;
      end
    endcase
  end

  always_comb begin
    w_code_valid = (r_state == S_EMIT);
    w_error      = (r_state == S_OVF) && (r_count == 32'd0) && !w_event;
  end

  assign bus.code       = r_code;
  assign bus.len        = r_len;
  assign bus.code_valid = w_code_valid;
  assign bus.error      = w_error;

endmodule
`default_nettype wire

// File: tb/tb_press_sequence_decoder.sv
`default_nettype none
// ============================================================================
// tb_press_sequence_decoder : vector table, corner sequences and random traffic
// against a word-level reference model. Rev 1.0
// ============================================================================
module tb_press_sequence_decoder;

  localparam int GAP    = 4;
  localparam int MAXLEN = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  press_sequence_decoder_if #(.maxlen(MAXLEN)) bus ();

  press_sequence_decoder #(.gap(GAP), .maxlen(MAXLEN)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit         s;
    bit         l;
    bit         cv;
    bit         er;
    logic [3:0] code;
    logic [2:0] len;
  } vec_t;

  vec_t tab[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Word-level model: symbol list plus edges elapsed since the last event.
  bit m_active;
  bit m_ovf;
  int m_idle;
  bit m_q[$];

  logic       obs_cv, obs_err;
  logic [3:0] obs_code;
  logic [2:0] obs_len;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic logic [3:0] m_code();
    logic [3:0] c = '0;
    foreach (m_q[i]) c = {c[2:0], m_q[i]};
    return c;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_ovf    = 1'b0;
    m_idle   = 0;
    m_q.delete();
  endtask

  task automatic model_edge(input bit s, input bit l);
    bit ev;
    ev = s | l;
    if (ev) begin
      if (m_active && m_idle <= GAP) begin
        if (!m_ovf) begin
          if (m_q.size() < MAXLEN) m_q.push_back(l);
          else m_ovf = 1'b1;
        end
      end else begin
        m_q.delete();
        m_q.push_back(l);
        m_ovf    = 1'b0;
        m_active = 1'b1;
      end
      m_idle = 0;
    end else if (m_active) begin
      if (m_ovf && m_idle == GAP) begin
        m_q.delete();
        m_active = 1'b0;
        m_ovf    = 1'b0;
      end else if (m_idle == GAP + 1) begin
        m_active = 1'b0;
      end else begin
        m_idle++;
      end
    end
  endtask

  task automatic drive_sample(input bit s, input bit l);
    @(negedge clk);
    bus.short = s;
    bus.long  = l;
    #1;
    obs_cv   = bus.code_valid;
    obs_err  = bus.error;
    obs_code = bus.code;
    obs_len  = bus.len;
  endtask

  task automatic step(input bit s, input bit l, input string tag);
    logic       e_cv, e_err;
    logic [2:0] e_len;
    drive_sample(s, l);
    e_cv  = m_active && !m_ovf && (m_idle == GAP + 1);
    e_err = m_active && m_ovf && (m_idle == GAP) && !(s | l);
    e_len = 3'(m_q.size());
    chk(tag, {23'd0, obs_cv, obs_err, obs_code, obs_len},
             {23'd0, e_cv, e_err, m_code(), e_len});
    @(posedge clk);
    model_edge(s, l);
  endtask

  function automatic void add(bit s, bit l, bit cv, bit er, logic [3:0] code,
                              logic [2:0] len, int reps);
    vec_t v;
    v = '{s: s, l: l, cv: cv, er: er, code: code, len: len};
    for (int i = 0; i < reps; i++) tab.push_back(v);
  endfunction

  initial begin
    int         err_k, err_n, cv_k;
    bit         cv_seen;
    logic [3:0] cap_code;
    logic [2:0] cap_len;

    rst_n     = 1'b0;
    bus.short = 1'b0;
    bus.long  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_state", {bus.code_valid, bus.error, bus.code, bus.len}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // short, long, short two cycles apart; then a simultaneous short+long.
    add(1, 0, 0, 0, 4'h0, 3'd0, 1);
    add(0, 0, 0, 0, 4'h0, 3'd1, 1);
    add(0, 1, 0, 0, 4'h0, 3'd1, 1);
    add(0, 0, 0, 0, 4'h1, 3'd2, 1);
    add(1, 0, 0, 0, 4'h1, 3'd2, 1);
    add(0, 0, 0, 0, 4'h2, 3'd3, 5);
    add(0, 0, 1, 0, 4'h2, 3'd3, 1);
    add(0, 0, 0, 0, 4'h2, 3'd3, 2);
    add(1, 1, 0, 0, 4'h2, 3'd3, 1);
    add(0, 0, 0, 0, 4'h1, 3'd1, 5);
    add(0, 0, 1, 0, 4'h1, 3'd1, 1);
    add(0, 0, 0, 0, 4'h1, 3'd1, 1);

    foreach (tab[i]) begin
      drive_sample(tab[i].s, tab[i].l);
      chk($sformatf("vec%0d", i), {obs_cv, obs_err, obs_code, obs_len},
          {tab[i].cv, tab[i].er, tab[i].code, tab[i].len});
      @(posedge clk);
      model_edge(tab[i].s, tab[i].l);
    end

    // Five back-to-back shorts overflow a 4-symbol word.
    for (int i = 0; i < 5; i++) step(1, 0, "ovf_in");
    err_k = -1; err_n = 0; cv_seen = 0;
    for (int k = 0; k < 7; k++) begin
      step(0, 0, "ovf_wait");
      if (obs_err) begin
        err_n++;
        if (err_k < 0) err_k = k;
      end
      if (obs_cv) cv_seen = 1;
    end
    chk("ovf_err_cycle", err_k, GAP);
    chk("ovf_err_count", err_n, 1);
    chk("ovf_no_valid", {31'd0, cv_seen}, 0);
    chk("ovf_len_cleared", {29'd0, obs_len}, 0);

    step(1, 0, "after_ovf");
    cap_code = 'x; cap_len = 'x;
    for (int k = 0; k < 7; k++) begin
      step(0, 0, "after_ovf_wait");
      if (obs_cv) begin cap_code = obs_code; cap_len = obs_len; end
    end
    chk("after_ovf_code", {28'd0, cap_code}, 0);
    chk("after_ovf_len", {29'd0, cap_len}, 1);

    // long,long then a short landing in the emit cycle.
    step(0, 1, "emit_in");
    step(0, 1, "emit_in");
    for (int k = 0; k <= GAP; k++) step(0, 0, "emit_wait");
    step(1, 0, "emit_new");
    chk("emit_cv", {31'd0, obs_cv}, 1);
    chk("emit_code", {28'd0, obs_code}, 32'h3);
    chk("emit_len", {29'd0, obs_len}, 2);
    step(0, 0, "emit_next");
    chk("emit_next_len", {29'd0, obs_len}, 1);
    chk("emit_next_code", {28'd0, obs_code}, 0);
    cv_k = -1;
    for (int k = 1; k < 8; k++) begin
      step(0, 0, "emit_next_wait");
      if (obs_cv && cv_k < 0) begin cv_k = k; cap_len = obs_len; end
    end
    chk("emit_next_strobe_at", cv_k, GAP + 1);
    chk("emit_next_strobe_len", {29'd0, cap_len}, 1);

    // Event exactly in the count==0 cycle extends the word.
    step(1, 0, "cnt0_in");
    for (int k = 0; k < GAP; k++) step(0, 0, "cnt0_wait");
    step(1, 0, "cnt0_hit");
    chk("cnt0_no_cv_yet", {31'd0, obs_cv}, 0);
    cv_k = -1;
    for (int k = 0; k < 8; k++) begin
      step(0, 0, "cnt0_after");
      if (obs_cv && cv_k < 0) begin cv_k = k; cap_len = obs_len; cap_code = obs_code; end
    end
    chk("cnt0_strobe_at", cv_k, GAP + 1);
    chk("cnt0_len", {29'd0, cap_len}, 2);
    chk("cnt0_code", {28'd0, cap_code}, 0);

    // Asynchronous reset mid-word.
    step(0, 1, "rst_in");
    step(1, 0, "rst_in");
    @(negedge clk);
    bus.short = 1'b0;
    bus.long  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_word", {bus.code_valid, bus.error, bus.code, bus.len}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cv_seen = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, 0, "post_rst");
      if (obs_cv || obs_err) cv_seen = 1;
    end
    chk("post_rst_no_strobe", {31'd0, cv_seen}, 0);

    // Random traffic with varying event density.
    for (int p = 0; p < 15; p++) begin
      int dens;
      dens = $urandom_range(5, 45);
      for (int c = 0; c < 200; c++) begin
        bit s, l;
        s = 0; l = 0;
        if ($urandom_range(0, 99) < dens) begin
          case ($urandom_range(0, 2))
            0:       s = 1;
            1:       l = 1;
            default: begin s = 1; l = 1; end
          endcase
        end
        step(s, l, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
